// File: rtl/i2c_io_master_pkg.sv
// Shared types and defaults for the two-requester I2C I/O-extender master.
package i2c_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK_A = 3'd3,
        DATA  = 3'd4,
        ACK_D = 3'd5,
        STOP  = 3'd6
    } state_e;

    // Index of the current quarter within one SCL bit-time.
    typedef logic [1:0] quarter_t;

    localparam int         DEF_CLK_DIV   = 125;
    localparam logic [6:0] DEF_SLAVE_ADR = 7'h27;

endpackage

// File: rtl/i2c_io_master_if.sv
// Requester-side handshake bundle of the I2C master.
interface i2c_io_master_if;

    logic [1:0] req;
    logic [1:0] rnw;
    logic [7:0] wr_data0;
    logic [7:0] wr_data1;
    logic [1:0] done;
    logic       nack;
    logic [7:0] rd_data;
    logic       busy;

    modport master (
        input  req, rnw, wr_data0, wr_data1,
        output done, nack, rd_data, busy
    );

    modport slave (
        output req, rnw, wr_data0, wr_data1,
        input  done, nack, rd_data, busy
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one tick every CLK_DIV cycles while enabled.
module i2c_tick_gen
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     en,
    output logic     tick,
    output quarter_t q
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= '0;
        end else if (clr) begin
            cnt <= '0;
            q   <= '0;
        end else if (tick) begin
            cnt <= '0;
            q   <= q + 2'd1;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_io_master.sv
// One-byte I2C write/read sequencer to an I/O extender, shared round-robin by two requesters.
module i2c_io_master
    import i2c_master_pkg::*;
#(
    parameter int         CLK_DIV   = DEF_CLK_DIV,
    parameter logic [6:0] SLAVE_ADR = DEF_SLAVE_ADR
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_io_master_if.master   bus,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              sda_in
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_ADDR  = 3'(ADDR);
    localparam logic [2:0] S_ACK_A = 3'(ACK_A);
    localparam logic [2:0] S_DATA  = 3'(DATA);
    localparam logic [2:0] S_ACK_D = 3'(ACK_D);
    localparam logic [2:0] S_STOP  = 3'(STOP);

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] wr_byte;
    logic [7:0] rd_byte;
    logic [1:0] done_r;
    logic [1:0] sync;
    logic       op_rd, owner, last, nack_flag, nack_r;
    logic       busy, grant, winner, tick, end_bit, sample, sda_s;
    quarter_t   q;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant),
        .en    (busy),
        .tick  (tick),
        .q     (q)
    );

    assign busy    = (state != S_IDLE);
    // No grant while done is pulsing, so a requester always sees done before it can be re-served.
    assign grant   = !busy && (done_r == 2'b00) && (bus.req != 2'b00);
    assign winner  = (bus.req == 2'b11) ? ~last : bus.req[1];
    assign end_bit = tick && (q == 2'd3);
    assign sample  = tick && (q == 2'd2);
    assign sda_s   = sync[1];

    assign bus.busy    = busy;
    assign bus.done    = done_r;
    assign bus.nack    = nack_r;
    assign bus.rd_data = rd_byte;

    // Idle bus reads high, so the synchronizer resets to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], sda_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            wr_byte   <= '0;
            rd_byte   <= '0;
            op_rd     <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
            nack_flag <= 1'b0;
            done_r    <= '0;
            nack_r    <= 1'b0;
        end else begin
            done_r <= '0;
            nack_r <= 1'b0;
            case (state)
                S_IDLE: if (grant) begin
                    state     <= S_START;
                    owner     <= winner;
                    last      <= winner;
                    op_rd     <= bus.rnw[winner];
                    wr_byte   <= winner ? bus.wr_data1 : bus.wr_data0;
                    shreg     <= {SLAVE_ADR, bus.rnw[winner]};
                    nack_flag <= 1'b0;
                    bit_cnt   <= '0;
                end
                S_START: if (end_bit) state <= S_ADDR;
                S_ADDR: if (end_bit) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= S_ACK_A;
                end
                S_ACK_A: begin
                    if (sample && sda_s) nack_flag <= 1'b1;
                    if (end_bit) begin
                        state <= nack_flag ? S_STOP : S_DATA;
                        shreg <= wr_byte;
                    end
                end
                S_DATA: begin
                    if (sample && op_rd) shreg <= {shreg[6:0], sda_s};
                    if (end_bit) begin
                        if (!op_rd) shreg <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_ACK_D;
                            if (op_rd) rd_byte <= shreg;
                        end
                    end
                end
                S_ACK_D: begin
                    if (sample && !op_rd && sda_s) nack_flag <= 1'b1;
                    if (end_bit) state <= S_STOP;
                end
                S_STOP: if (end_bit) begin
                    state  <= S_IDLE;
                    done_r <= owner ? 2'b10 : 2'b01;
                    nack_r <= nack_flag;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: defaults first in combinational blocks so no path leaves an output unassigned (no latches).
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            S_START: begin
                sda_oe = q[1];
                scl_oe = (q == 2'd3);
            end
            S_ADDR: begin
                scl_oe = ~q[1];
                sda_oe = ~shreg[7];
            end
            S_DATA: begin
                scl_oe = ~q[1];
                sda_oe = !op_rd && !shreg[7];
            end
            S_ACK_A, S_ACK_D: scl_oe = ~q[1];
            S_STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = ~q[1];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_io_master.sv
// Directed bench: open-drain bus with pull-ups, I/O-extender slave at 0x27, second master addressing 0x28.
module tb_i2c_io_master;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    i2c_io_master_if bus_a ();
    i2c_io_master_if bus_b ();

    logic scl_oe_a, sda_oe_a, scl_oe_b, sda_oe_b;
    logic s_oe = 1'b0;
    wire  scl_a = ~scl_oe_a;
    wire  sda_a = ~(sda_oe_a | s_oe);
    wire  scl_b = ~scl_oe_b;
    wire  sda_b = ~sda_oe_b;

    i2c_io_master #(.CLK_DIV(4), .SLAVE_ADR(7'h27)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus_a),
        .scl_oe (scl_oe_a), .sda_oe (sda_oe_a), .sda_in (sda_a)
    );

    i2c_io_master #(.CLK_DIV(4), .SLAVE_ADR(7'h28)) u_dut_nack (
        .clk (clk), .rst_n (rst_n), .bus (bus_b),
        .scl_oe (scl_oe_b), .sda_oe (sda_oe_b), .sda_in (sda_b)
    );

    // I/O-extender slave at 0x27: write stores port_reg, read returns it.
    int         ph = 0;
    int         bcnt = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] port_reg = 8'hFF;
    logic [7:0] addr_byte = 8'h00;
    logic       rack_sda = 1'b0;
    logic       rd_op = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    always @(scl_a or sda_a) begin
        if (scl_a && scl_p && sda_p && !sda_a) begin
            ph = 1; bcnt = 0; s_oe = 1'b0;
        end else if (scl_a && scl_p && !sda_p && sda_a) begin
            ph = 0; s_oe = 1'b0;
        end else if (scl_a && !scl_p) begin
            case (ph)
                1: begin
                    sh = {sh[6:0], sda_a}; bcnt++;
                    if (bcnt == 8) begin
                        addr_byte = sh; rd_op = sh[0];
                        ph = (sh[7:1] == 7'h27) ? 2 : 0;
                    end
                end
                2: begin ph = rd_op ? 5 : 3; bcnt = 0; end
                3: begin
                    sh = {sh[6:0], sda_a}; bcnt++;
                    if (bcnt == 8) begin port_reg = sh; ph = 4; end
                end
                4: ph = 7;
                5: begin bcnt++; if (bcnt == 8) ph = 6; end
                6: begin rack_sda = sda_a; ph = 0; end
                default: ;
            endcase
        end else if (!scl_a && scl_p) begin
            case (ph)
                2, 4:    s_oe = 1'b1;
                5:       s_oe = ~port_reg[3'(7 - bcnt)];
                default: s_oe = 1'b0;
            endcase
        end
        scl_p = scl_a;
        sda_p = sda_a;
    end

    int scl_rise_b = 0;
    always @(posedge scl_b) scl_rise_b++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant then for done; latency is posedges from busy rise to done rise.
    task automatic wait_txn(input bit sel, output logic [1:0] dn, output logic nk, output int lat);
        int  t0;
        bit  seen;
        seen = 1'b0; dn = 2'b00; nk = 1'b0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            if ((sel ? bus_b.busy : bus_a.busy) === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) return;
        t0 = cyc;
        for (int i = 0; i < 2000; i++) begin
            if ((sel ? bus_b.done : bus_a.done) !== 2'b00) begin
                dn  = sel ? bus_b.done : bus_a.done;
                nk  = sel ? bus_b.nack : bus_a.nack;
                lat = cyc - t0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [1:0] dn;
        logic       nk;
        int         lat;
        int         snap;

        rst_n = 1'b0;
        bus_a.req = 2'b00; bus_a.rnw = 2'b00; bus_a.wr_data0 = 8'h00; bus_a.wr_data1 = 8'h00;
        bus_b.req = 2'b00; bus_b.rnw = 2'b00; bus_b.wr_data0 = 8'h00; bus_b.wr_data1 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_scl_oe",  32'(scl_oe_a), 32'(1'b0));
        check("rst_sda_oe",  32'(sda_oe_a), 32'(1'b0));
        check("rst_busy",    32'(bus_a.busy), 32'(1'b0));
        check("rst_done",    32'(bus_a.done), 32'(2'b00));
        check("rst_nack",    32'(bus_a.nack), 32'(1'b0));
        check("rst_rd_data", 32'(bus_a.rd_data), 32'(8'h00));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0xA5 from requester 0.
        bus_a.rnw = 2'b10; bus_a.wr_data0 = 8'hA5; bus_a.wr_data1 = 8'h00;
        bus_a.req = 2'b01;
        wait_txn(1'b0, dn, nk, lat);
        bus_a.req = 2'b00;
        check("wr_done",    32'(dn), 32'(2'b01));
        check("wr_nack",    32'(nk), 32'(1'b0));
        check("wr_latency", 32'(lat), 32'(320));
        check("wr_addr",    32'(addr_byte), 32'(8'h4E));
        check("wr_port",    32'(port_reg), 32'(8'hA5));
        @(negedge clk);
        check("wr_done_pulse", 32'(bus_a.done), 32'(2'b00));
        check("wr_busy_low",   32'(bus_a.busy), 32'(1'b0));

        // Read back from requester 1.
        bus_a.wr_data0 = 8'h00;
        bus_a.req = 2'b10;
        wait_txn(1'b0, dn, nk, lat);
        bus_a.req = 2'b00;
        check("rd_done",     32'(dn), 32'(2'b10));
        check("rd_nack",     32'(nk), 32'(1'b0));
        check("rd_latency",  32'(lat), 32'(320));
        check("rd_addr",     32'(addr_byte), 32'(8'h4F));
        check("rd_data",     32'(bus_a.rd_data), 32'(8'hA5));
        check("rd_ack_d_sda", 32'(rack_sda), 32'(1'b1));

        // A later write must not disturb rd_data.
        @(negedge clk);
        bus_a.rnw = 2'b00; bus_a.wr_data0 = 8'h3C;
        bus_a.req = 2'b01;
        wait_txn(1'b0, dn, nk, lat);
        bus_a.req = 2'b00;
        check("wr2_port",    32'(port_reg), 32'(8'h3C));
        check("wr2_rd_keep", 32'(bus_a.rd_data), 32'(8'hA5));

        // Address NACK on the master configured for 0x28 (no device answers there).
        snap = scl_rise_b;
        bus_b.rnw = 2'b01;
        bus_b.req = 2'b01;
        wait_txn(1'b1, dn, nk, lat);
        bus_b.req = 2'b00;
        check("nack_done",    32'(dn), 32'(2'b01));
        check("nack_flag",    32'(nk), 32'(1'b1));
        check("nack_latency", 32'(lat), 32'(176));
        check("nack_scl_clocks", 32'(scl_rise_b - snap), 32'(10));
        check("nack_rd_data", 32'(bus_b.rd_data), 32'(8'h00));
        @(negedge clk);
        check("nack_pulse", 32'(bus_b.nack), 32'(1'b0));

        // Contention from reset: both held high, service alternates 0,1,0,1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_a.rnw = 2'b00; bus_a.wr_data0 = 8'h11; bus_a.wr_data1 = 8'h22;
        bus_a.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_txn(1'b0, dn, nk, lat);
            check("rr_done", 32'(dn), (k % 2 == 1) ? 32'(2'b10) : 32'(2'b01));
            check("rr_port", 32'(port_reg), (k % 2 == 1) ? 32'(8'h22) : 32'(8'h11));
            if (k < 3) @(negedge clk);
        end
        bus_a.req = 2'b00;
        @(negedge clk);

        // Reset during DATA (write 0x5A, bit-time 12, quarter 1: SCL and SDA both pulled).
        bus_a.wr_data0 = 8'h5A;
        bus_a.req = 2'b01;
        for (int i = 0; i < 100 && bus_a.busy !== 1'b1; i++) @(negedge clk);
        repeat (196) @(negedge clk);
        check("pre_rst_scl_oe", 32'(scl_oe_a), 32'(1'b1));
        check("pre_rst_sda_oe", 32'(sda_oe_a), 32'(1'b1));
        rst_n = 1'b0;
        bus_a.req = 2'b00;
        #1;
        check("mid_rst_scl_oe", 32'(scl_oe_a), 32'(1'b0));
        check("mid_rst_sda_oe", 32'(sda_oe_a), 32'(1'b0));
        check("mid_rst_busy",   32'(bus_a.busy), 32'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_a.wr_data0 = 8'hC3;
        bus_a.req = 2'b01;
        wait_txn(1'b0, dn, nk, lat);
        bus_a.req = 2'b00;
        check("post_rst_done",    32'(dn), 32'(2'b01));
        check("post_rst_nack",    32'(nk), 32'(1'b0));
        check("post_rst_latency", 32'(lat), 32'(320));
        check("post_rst_port",    32'(port_reg), 32'(8'hC3));
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_io_master.md
# i2c_io_master

Single-clock I2C master that sequences one-byte write and read transactions to the 8-bit I2C I/O extender. It shares that one bus between two on-chip requesters with round-robin arbitration. It sits between the system-clock fabric and the open-drain SCL/SDA pads and drives both lines as open-drain enables only. Each transaction is START, address+R/W, ACK, one data byte, ACK/NACK, STOP.

## Interface
- `CLK_DIV`, default 125: clk cycles per SCL quarter-period; SCL period = 4·CLK_DIV (100 kHz at 50 MHz); legal values ≥ 4.
- `SLAVE_ADR`, default 7'h27: 7-bit target address.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester request level; held until matching `done` bit.
- `rnw`  in  2  per-requester op: 1 = read, 0 = write; sampled at grant.
- `wr_data0`, `wr_data1`  in  8  write byte per requester; sampled at grant.
- `done`  out  2  one-cycle completion pulse to the granted requester.
- `nack`  out  1  valid with `done`: 1 = slave did not ACK (address or write data).
- `rd_data`  out  8  read byte; updated only on a successful read, stable until the next one.
- `busy`  out  1  transaction in progress.
- `scl_oe`  out  1  1 = pull SCL low.
- `sda_oe`  out  1  1 = pull SDA low.
- `sda_in`  in  1  SDA pad input, asynchronous.

## Operation
- `sda_in` passes through a 2-flop synchronizer before use.
- Arbitration happens in IDLE only. With one request pending, it is granted. With both pending, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins first.
- At grant, `rnw`/`wr_data` of the winner are latched, `busy`=1 and the quarter counter clears.
- State machine:
  - IDLE → START → ADDR (8 bits, MSB first, {SLAVE_ADR, rnw}) → ACK_A.
  - ACK_A with SDA high → STOP, `nack`=1, no data phase.
  - ACK_A with SDA low → DATA (8 bits) → ACK_D → STOP → IDLE.
- Write: DATA drives `wr_data`. In ACK_D the master releases SDA and samples it; high sets `nack`=1.
- Read: DATA releases SDA and shifts in 8 samples, MSB first. In ACK_D the master releases SDA (NACK, ends the read), and `rd_data` loads the shifted byte.
- `sda_oe` is always the inverse of the intended bit. It is never asserted in ADDR/DATA bit-time of a read data byte or in either ACK bit-time.

## Timing
- The tick generator pulses once every CLK_DIV cycles while `busy`; each tick advances the quarter index q0→q3.
- Data bit: q0/q1 SCL low, SDA updated at q0 start; q2/q3 SCL released; SDA sampled (synchronized value) on the tick ending q2.
- START bit-time: q0–q1 both released; q2 SDA low; q3 SDA low and SCL low.
- STOP bit-time: q0 SCL low, SDA low; q1 SCL released; q2–q3 SDA released.
- Full transaction is 20 bit-times = 80·CLK_DIV cycles from grant to `done`. Address NACK is 11 bit-times = 44·CLK_DIV cycles.
- `done[i]` and `nack` pulse in the cycle after the final STOP tick; `busy` falls in the same cycle. The earliest next grant is the following cycle.
- A requester dropping `req` mid-transaction has no effect; the transaction completes.
- Reset values: `scl_oe`=0, `sda_oe`=0, `done`=0, `nack`=0, `rd_data`=8'h00, `busy`=0, state IDLE.
- Reset mid-transaction releases both lines immediately (asynchronous) without a STOP. The next transaction begins with a fresh START.
- Clock stretching and multi-master arbitration are not supported.

## Structure
- Package `i2c_master_pkg`: state enum (IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP), 2-bit quarter typedef, default `CLK_DIV`/`SLAVE_ADR` constants.
- Sub-module `i2c_tick_gen`: CLK_DIV counter with synchronous clear at grant and enable = `busy`; emits the tick pulse and quarter index.
- Top holds the arbiter, the FSM, the 3-bit bit counter, the shift register and the synchronizer.

## Test plan
- Bench uses `CLK_DIV`=4 and an open-drain bus model with pull-ups plus an I2C I/O-extender slave model at 0x27.
- Write: req0 with `rnw0`=0, `wr_data0`=8'hA5 → slave output 8'hA5; `done`=2'b01 with `nack`=0 at exactly 80·4 cycles after grant.
- Read: after the write, req1 with `rnw1`=1 → `rd_data`=8'hA5, `done`=2'b10, `nack`=0; SDA released by the master during ACK_D.
- Address NACK: `SLAVE_ADR`=7'h28 → `done` with `nack`=1 after 44·4 cycles; no data clocks; `rd_data` unchanged.
- Contention: req0 and req1 both asserted in the same cycle from reset → 0 served, then 1. Repeated pairs with both held high alternate 0,1,0,1.
- Reset: `rst_n` low during the DATA phase → `scl_oe`=`sda_oe`=`busy`=0 in the same cycle. After release, a new write completes correctly with a clean START.
